opb_arbiter_rr: RTL and testbench
=================================

OPB_ARBITER_RR -- requirements
Module: opb_arbiter_rr

Interface
REQ-001 Parameter C_NUM_MASTERS, default 4, number of OPB masters sharing the bus (legal 2..8).
REQ-002 Parameter C_TIMEOUT, default 16, OPB cycles without slave response before timeout (legal 4..255).
REQ-003 Parameter C_PARK, default 1, when 1 the last owner keeps grant while no master requests.
REQ-004 OPB_Clk  in  1  single clock; all logic rising-edge.
REQ-005 OPB_Rst_n  in  1  asynchronous, active-low reset.
REQ-006 M_request  in  C_NUM_MASTERS  per-master bus request.
REQ-007 M_busLock  in  C_NUM_MASTERS  per-master lock; holds grant across consecutive transfers.
REQ-008 M_select  in  C_NUM_MASTERS  per-master select, valid only from the granted master.
REQ-009 Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup  in  1 each  OR-reduced slave responses.
REQ-010 OPB_MGrant  out  C_NUM_MASTERS  one-hot or zero grant vector, registered.
REQ-011 OPB_select  out  1  M_select of the granted master; 0 when no grant.
REQ-012 OPB_timeout  out  1  one-cycle pulse on arbiter timeout.
REQ-013 grant_idx  out  clog2(C_NUM_MASTERS)  index of current or last owner.
REQ-014 arb_busy  out  1  high in GRANTED and XFER states.

Function
REQ-015 States: IDLE, GRANTED, XFER, REARB.
- IDLE: any M_request -> grant round-robin winner, next state GRANTED.
- GRANTED: granted M_select=1 -> XFER; granted M_request=0 with M_select=0 -> REARB.
- XFER: completion or abort (REQ-018..021) -> REARB, or GRANTED if lock held (REQ-019).
- REARB: rotate pointer, grant new winner if any request, else IDLE.
REQ-016 OPB_MGrant SHALL assert exactly one cycle after the request is first sampled in IDLE.
REQ-017 Round-robin: search starts at pointer; after each released tenure pointer = winner+1 mod C_NUM_MASTERS.
REQ-018 Sl_xferAck or Sl_errAck in XFER SHALL complete the transfer.
REQ-019 Completion with granted M_busLock=1 SHALL return to GRANTED with same owner; pointer unchanged.
REQ-020 Sl_retry in XFER SHALL release the grant regardless of M_busLock; pointer advances.
REQ-021 Granted M_select falling in XFER without a response SHALL be treated as abort -> REARB.
REQ-022 Timeout counter: cleared on entering XFER; increments each XFER cycle without a response; holds while Sl_toutSup=1.
REQ-023 Counter reaching C_TIMEOUT-1 with no response SHALL pulse OPB_timeout and go to REARB; M_busLock ignored.
REQ-024 Response and timeout in the same cycle: response wins, no OPB_timeout pulse.
REQ-025 Grant SHALL be low for exactly one cycle in REARB before a different owner is granted (no overlapping grants).
REQ-026 C_PARK=1: when entering IDLE, grant_idx retained and OPB_MGrant stays on that master until another master requests. C_PARK=0: OPB_MGrant=0 in IDLE.
REQ-027 M_select from a non-granted master SHALL be ignored.

Reset
REQ-028 Reset asserted: state IDLE, OPB_MGrant=0, OPB_timeout=0, pointer=0, grant_idx=0, counter=0, arb_busy=0, effective immediately.
REQ-029 Reset asserted during XFER SHALL drop grant immediately; first grant after release follows REQ-016 with pointer 0.

Structure
REQ-030 Package opb_arb_pkg SHALL hold the state enum, the clog2 function and the default parameter constants.
REQ-031 Sub-module rr_priority_pick (combinational; inputs request vector and pointer; output one-hot winner and index) SHALL implement the rotate-and-select.

Verification
REQ-032 N=4, reset release, M_request=4'b1010 -> OPB_MGrant=4'b0010 one cycle later; after ack, next grant 4'b1000.
REQ-033 All four requesting continuously, ack each tenure -> grant order 0,1,2,3,0; each grant preceded by one zero-grant cycle.
REQ-034 Master 2 holds M_busLock=1 across 3 acked transfers -> grant stays 4'b0100 throughout; pointer then moves to 3.
REQ-035 C_TIMEOUT=16, no response -> OPB_timeout pulses on 16th XFER cycle; Sl_toutSup=1 for 10 cycles delays the pulse by 10.
REQ-036 Sl_xferAck on the timeout cycle -> no OPB_timeout pulse; normal completion.
REQ-037 OPB_Rst_n low mid-XFER -> OPB_MGrant=0 same cycle; after release, M_request=4'b1111 -> grant 4'b0001.

Source files
------------

// File: rtl/opb_arb_pkg.sv
// Shared types and constants for the round-robin OPB arbiter.
package opb_arb_pkg;

   localparam int DEF_NUM_MASTERS = 4;
   localparam int DEF_TIMEOUT     = 16;
   localparam int DEF_PARK        = 1;
   localparam int CNT_W           = 8;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_GRANTED = 2'd1,
      S_XFER    = 2'd2,
      S_REARB   = 2'd3
   } arb_state_e;

   // Index width; never below one bit so ports stay legal.
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) begin
         r++;
      end
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating priority picker: first requester at or after the pointer.
module rr_priority_pick
   import opb_arb_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = clog2(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   output logic [N-1:0]  gnt_o,
   output logic [IW-1:0] idx_o,
   output logic          vld_o
);

   int   j;
   logic found;

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      found = 1'b0;
      j     = 0;
      for (int i = 0; i < N; i++) begin
         j = (int'(ptr_i) + i) % N;
         if (!found && req_i[j]) begin
            found    = 1'b1;
            gnt_o[j] = 1'b1;
            idx_o    = IW'(j);
         end
      end
      vld_o = found;
   end

endmodule

// File: rtl/opb_arbiter_rr.sv
// Round-robin OPB bus arbiter with bus lock, retry, abort,
// timeout and optional grant parking.
module opb_arbiter_rr
   import opb_arb_pkg::*;
#(
   parameter int C_NUM_MASTERS = DEF_NUM_MASTERS,
   parameter int C_TIMEOUT     = DEF_TIMEOUT,
   parameter int C_PARK        = DEF_PARK,
   localparam int IW           = clog2(C_NUM_MASTERS)
) (
   input  logic                     OPB_Clk,
   input  logic                     OPB_Rst_n,
   input  logic [C_NUM_MASTERS-1:0] M_request,
   input  logic [C_NUM_MASTERS-1:0] M_busLock,
   input  logic [C_NUM_MASTERS-1:0] M_select,
   input  logic                     Sl_xferAck,
   input  logic                     Sl_errAck,
   input  logic                     Sl_retry,
   input  logic                     Sl_toutSup,
   output logic [C_NUM_MASTERS-1:0] OPB_MGrant,
   output logic                     OPB_select,
   output logic                     OPB_timeout,
   output logic [IW-1:0]            grant_idx,
   output logic                     arb_busy
);

   localparam int N = C_NUM_MASTERS;
   localparam logic [CNT_W-1:0] TMAX = CNT_W'(C_TIMEOUT - 1);
   localparam logic [IW-1:0]    LAST = IW'(N - 1);

   arb_state_e       state_q, state_d;
   logic [N-1:0]     grant_q, grant_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic [IW-1:0]    ptr_q, ptr_d;
   logic [IW-1:0]    ptr_nxt;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [N-1:0]  pick_gnt;
   logic [IW-1:0] pick_idx;
   logic          pick_vld;

   logic own_req, own_sel, own_lock;
   logic resp, tout_hit, tout, rel;

   rr_priority_pick #(
      .N  (N),
      .IW (IW)
   ) u_pick (
      .req_i (M_request),
      .ptr_i (ptr_q),
      .gnt_o (pick_gnt),
      .idx_o (pick_idx),
      .vld_o (pick_vld)
   );

   assign own_req  = M_request[idx_q];
   assign own_sel  = M_select[idx_q];
   assign own_lock = M_busLock[idx_q];
   assign resp     = Sl_xferAck | Sl_errAck;
   assign ptr_nxt  = (idx_q == LAST) ? '0 : idx_q + IW'(1);
   assign tout_hit = (cnt_q == TMAX) && !Sl_toutSup;

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      idx_d   = idx_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      tout    = 1'b0;
      rel     = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (pick_vld) begin
               grant_d = pick_gnt;
               idx_d   = pick_idx;
               state_d = S_GRANTED;
            end
         end
         S_GRANTED: begin
            if (own_sel) begin
               state_d = S_XFER;
               cnt_d   = '0;
            end else if (!own_req) begin
               rel = 1'b1;
            end
         end
         S_XFER: begin
            // A response beats a coincident timeout.
            if (resp) begin
               if (own_lock) state_d = S_GRANTED;
               else          rel     = 1'b1;
            end else if (Sl_retry || !own_sel) begin
               rel = 1'b1;
            end else if (tout_hit) begin
               tout = 1'b1;
               rel  = 1'b1;
            end else if (!Sl_toutSup) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_REARB: begin
            if (pick_vld) begin
               grant_d = pick_gnt;
               idx_d   = pick_idx;
               state_d = S_GRANTED;
            end else begin
               state_d = S_IDLE;
               grant_d = '0;
               if (C_PARK != 0) grant_d[idx_q] = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      // Releasing always opens a one-cycle grant gap.
      if (rel) begin
         state_d = S_REARB;
         grant_d = '0;
         ptr_d   = ptr_nxt;
      end
   end

   always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
      if (!OPB_Rst_n) begin
         state_q <= S_IDLE;
         grant_q <= '0;
         idx_q   <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         idx_q   <= idx_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
      end
   end

   assign OPB_MGrant  = grant_q;
   assign OPB_select  = |(M_select & grant_q);
   assign OPB_timeout = tout;
   assign grant_idx   = idx_q;
   assign arb_busy    = (state_q == S_GRANTED) ||
                        (state_q == S_XFER);

endmodule

// File: tb/tb_opb_arbiter_rr.sv
// Directed and random checks of opb_arbiter_rr against a
// tenure-level reference model.
module tb_opb_arbiter_rr;

   localparam int NM   = 4;
   localparam int TOUT = 16;
   localparam int PARK = 1;

   logic          clk;
   logic          OPB_Rst_n;
   logic [NM-1:0] M_request, M_busLock, M_select;
   logic          Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup;
   logic [NM-1:0] OPB_MGrant;
   logic          OPB_select, OPB_timeout;
   logic [1:0]    grant_idx;
   logic          arb_busy;

   int errors = 0;
   int checks = 0;

   // Reference model: tenure-level view of the bus
   int m_owner, m_ptr, m_wait;
   bit m_has, m_inx, m_gap, m_park;
   logic obs_tout;

   opb_arbiter_rr #(
      .C_NUM_MASTERS (NM),
      .C_TIMEOUT     (TOUT),
      .C_PARK        (PARK)
   ) dut (
      .OPB_Clk     (clk),
      .OPB_Rst_n   (OPB_Rst_n),
      .M_request   (M_request),
      .M_busLock   (M_busLock),
      .M_select    (M_select),
      .Sl_xferAck  (Sl_xferAck),
      .Sl_errAck   (Sl_errAck),
      .Sl_retry    (Sl_retry),
      .Sl_toutSup  (Sl_toutSup),
      .OPB_MGrant  (OPB_MGrant),
      .OPB_select  (OPB_select),
      .OPB_timeout (OPB_timeout),
      .grant_idx   (grant_idx),
      .arb_busy    (arb_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int rr_winner(input logic [3:0] req, input int ptr);
      for (int k = 0; k < NM; k++)
         if (req[(ptr + k) % NM]) return (ptr + k) % NM;
      return -1;
   endfunction

   function automatic logic [3:0] exp_grant();
      return (m_has || m_park) ? 4'(1 << m_owner) : 4'b0000;
   endfunction

   function automatic logic [3:0] own();
      return 4'(1 << m_owner);
   endfunction

   task automatic model_reset();
      m_owner = 0; m_ptr = 0; m_wait = 0;
      m_has = 0; m_inx = 0; m_gap = 0; m_park = 0;
   endtask

   task automatic model_step(input logic [3:0] req, lock, sel,
                             input logic ack, err, rty, sup,
                             output logic tout);
      int w;
      bit rel;
      tout = 1'b0;
      rel  = 1'b0;
      w    = rr_winner(req, m_ptr);
      if (!m_has) begin
         if (w >= 0) begin
            m_owner = w; m_has = 1; m_park = 0;
         end else if (m_gap) begin
            m_park = (PARK != 0);
         end
         m_gap = 0;
      end else if (!m_inx) begin
         if (sel[m_owner]) begin
            m_inx = 1; m_wait = 0;
         end else if (!req[m_owner]) rel = 1;
      end else begin
         if (ack || err) begin
            if (lock[m_owner]) m_inx = 0;
            else rel = 1;
         end else if (rty || !sel[m_owner]) rel = 1;
         else if (m_wait == TOUT - 1 && !sup) begin
            tout = 1'b1; rel = 1;
         end else if (!sup) m_wait++;
      end
      if (rel) begin
         m_has = 0; m_inx = 0; m_gap = 1; m_park = 0;
         m_ptr = (m_owner + 1) % NM;
      end
   endtask

   task automatic cycle(input logic [3:0] req, lock, sel,
                        input logic ack, err, rty, sup);
      logic e_sel, e_tout;
      @(negedge clk);
      M_request = req; M_busLock = lock; M_select = sel;
      Sl_xferAck = ack; Sl_errAck = err;
      Sl_retry = rty; Sl_toutSup = sup;
      #1;
      e_sel = (m_has || m_park) ? sel[m_owner] : 1'b0;
      model_step(req, lock, sel, ack, err, rty, sup, e_tout);
      obs_tout = OPB_timeout;
      chk("select", OPB_select, e_sel);
      chk("timeout", OPB_timeout, e_tout);
      @(posedge clk);
      #1;
      chk("grant", OPB_MGrant, exp_grant());
      chk("idx", grant_idx, m_owner);
      chk("busy", arb_busy, m_has);
   endtask

   task automatic do_reset();
      OPB_Rst_n = 1'b0;
      M_request = '0; M_busLock = '0; M_select = '0;
      Sl_xferAck = 0; Sl_errAck = 0; Sl_retry = 0; Sl_toutSup = 0;
      #1;
      model_reset();
      chk("rst_grant", OPB_MGrant, 4'b0000);
      chk("rst_idx", grant_idx, 0);
      chk("rst_busy", arb_busy, 1'b0);
      chk("rst_tout", OPB_timeout, 1'b0);
      repeat (2) @(negedge clk);
      OPB_Rst_n = 1'b1;
   endtask

   initial begin
      logic [3:0] rq, lk, sl;
      do_reset();

      // Two requesters, ack, next in rotation
      cycle(4'b1010, 4'b0, 4'b0, 0, 0, 0, 0);
      chk("r032_first", OPB_MGrant, 4'b0010);
      cycle(4'b1010, 4'b0, own(), 0, 0, 0, 0);
      cycle(4'b1010, 4'b0, own(), 1, 0, 0, 0);
      chk("r032_gap", OPB_MGrant, 4'b0000);
      cycle(4'b1010, 4'b0, 4'b0, 0, 0, 0, 0);
      chk("r032_next", OPB_MGrant, 4'b1000);

      // Everyone requesting: 0,1,2,3,0 with gaps
      do_reset();
      cycle(4'b1111, 4'b0, 4'b0, 0, 0, 0, 0);
      for (int k = 0; k < 5; k++) begin
         chk("r033_order", OPB_MGrant, 4'b0001 << (k % 4));
         cycle(4'b1111, 4'b0, own(), 0, 0, 0, 0);
         cycle(4'b1111, 4'b0, own(), 1, 0, 0, 0);
         chk("r033_gap", OPB_MGrant, 4'b0000);
         cycle(4'b1111, 4'b0, 4'b0, 0, 0, 0, 0);
      end

      // Locked master 2 over three transfers
      do_reset();
      cycle(4'b0100, 4'b0100, 4'b0, 0, 0, 0, 0);
      for (int k = 0; k < 3; k++) begin
         cycle(4'b1111, 4'b0100, own(), 0, 0, 0, 0);
         cycle(4'b1111, 4'b0100, own(), 1, 0, 0, 0);
         chk("r034_hold", OPB_MGrant, 4'b0100);
      end
      cycle(4'b1011, 4'b0, 4'b0, 0, 0, 0, 0);
      cycle(4'b1011, 4'b0, 4'b0, 0, 0, 0, 0);
      chk("r034_after", OPB_MGrant, 4'b1000);

      // Foreign select ignored, then parking
      do_reset();
      cycle(4'b0010, 4'b0, 4'b0, 0, 0, 0, 0);
      cycle(4'b0010, 4'b0, 4'b0100, 0, 0, 0, 0);
      chk("r027_busy", arb_busy, 1'b1);
      cycle(4'b0010, 4'b0, own(), 0, 0, 0, 0);
      cycle(4'b0000, 4'b0, own(), 1, 0, 0, 0);
      cycle(4'b0000, 4'b0, 4'b0, 0, 0, 0, 0);
      chk("park_grant", OPB_MGrant, 4'b0010);
      chk("park_busy", arb_busy, 1'b0);
      cycle(4'b1000, 4'b0, 4'b0, 0, 0, 0, 0);
      chk("park_move", OPB_MGrant, 4'b1000);

      // Retry overrides lock
      do_reset();
      cycle(4'b0001, 4'b0001, 4'b0, 0, 0, 0, 0);
      cycle(4'b0001, 4'b0001, own(), 0, 0, 0, 0);
      cycle(4'b1111, 4'b0001, own(), 0, 0, 1, 0);
      chk("retry_gap", OPB_MGrant, 4'b0000);
      cycle(4'b1111, 4'b0001, 4'b0, 0, 0, 0, 0);
      chk("retry_next", OPB_MGrant, 4'b0010);

      // Timeout on 16th transfer cycle
      do_reset();
      cycle(4'b0001, 4'b0, 4'b0, 0, 0, 0, 0);
      cycle(4'b0001, 4'b0, own(), 0, 0, 0, 0);
      for (int i = 1; i <= 16; i++) begin
         cycle(4'b0001, 4'b0, 4'b0001, 0, 0, 0, 0);
         chk("r035_tout", obs_tout, (i == 16));
      end
      chk("r035_drop", OPB_MGrant, 4'b0000);

      // Suppression for 10 cycles delays by 10
      do_reset();
      cycle(4'b0001, 4'b0, 4'b0, 0, 0, 0, 0);
      cycle(4'b0001, 4'b0, own(), 0, 0, 0, 0);
      for (int i = 1; i <= 26; i++) begin
         cycle(4'b0001, 4'b0, 4'b0001, 0, 0, 0,
               (i >= 4 && i <= 13));
         chk("r035_sup", obs_tout, (i == 26));
      end

      // Ack on the timeout cycle wins
      do_reset();
      cycle(4'b0001, 4'b0, 4'b0, 0, 0, 0, 0);
      cycle(4'b0001, 4'b0, own(), 0, 0, 0, 0);
      for (int i = 1; i <= 16; i++) begin
         cycle(4'b0001, 4'b0, 4'b0001, (i == 16), 0, 0, 0);
         chk("r036_tout", obs_tout, 1'b0);
      end
      chk("r036_done", OPB_MGrant, 4'b0000);

      // Reset in the middle of a transfer
      do_reset();
      cycle(4'b0100, 4'b0, 4'b0, 0, 0, 0, 0);
      cycle(4'b0100, 4'b0, own(), 0, 0, 0, 0);
      cycle(4'b0100, 4'b0, own(), 0, 0, 0, 0);
      @(negedge clk);
      #2;
      do_reset();
      cycle(4'b1111, 4'b0, 4'b0, 0, 0, 0, 0);
      chk("r037_first", OPB_MGrant, 4'b0001);

      // Random traffic against the model
      do_reset();
      for (int n = 0; n < 400; n++) begin
         rq = 4'($urandom);
         lk = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
         sl = 4'($urandom) & 4'($urandom);
         if (m_has && $urandom_range(0, 9) != 0) sl = sl | own();
         cycle(rq, lk, sl,
               ($urandom_range(0, 4) == 0),
               ($urandom_range(0, 19) == 0),
               ($urandom_range(0, 29) == 0),
               ($urandom_range(0, 9) == 0));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
